// File: rtl/onoff_pkg.sv
// Shared definitions for the on/off resource arbiter: latch levels and FSM encoding.
package onoff_pkg;

    localparam logic LVL_ON  = 1'b1;
    localparam logic LVL_OFF = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/onoff_cell.sv
// Shared on/off latch: a set pulse turns it on, a clear pulse turns it off.
module onoff_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_out
);
    import onoff_pkg::*;

    logic r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= LVL_OFF;
        end else if (i_j && (r_out == LVL_OFF)) begin
            r_out <= LVL_ON;
        end else if (i_k && (r_out == LVL_ON)) begin
            r_out <= LVL_OFF;
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/onoff_resource_arbiter.sv
// Round-robin arbiter that shares one on/off latch among N requesters and
// enforces a minimum dwell after every level change.
module onoff_resource_arbiter #(
    parameter int N     = 4,
    parameter int DWELL = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_want_on,
    output logic [N-1:0] o_gnt,
    output logic [N-1:0] o_ack,
    output logic         o_state_out,
    output logic         o_busy
);
    import onoff_pkg::*;

    localparam int DW_W = $clog2(DWELL + 1);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;

    state_t          r_state;
    state_t          w_stateNext;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptrNext;
    logic [PW-1:0]   r_win;
    logic [PW-1:0]   w_winNext;
    logic [PW-1:0]   w_pick;
    logic            w_found;
    logic [DW_W-1:0] r_cnt;
    logic [DW_W-1:0] w_cntNext;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gntNext;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    w_ackNext;
    logic            w_j;
    logic            w_k;
    logic            w_latch;

    // Scan upward from the pointer with wrap-around; the first pending request wins.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % N]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_ptr) + i) % N);
            end
        end
    end

    assign w_j = (r_state == ST_GRANT) & i_req[r_win] & i_want_on[r_win]  & (w_latch == LVL_OFF);
    assign w_k = (r_state == ST_GRANT) & i_req[r_win] & ~i_want_on[r_win] & (w_latch == LVL_ON);

    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_winNext   = r_win;
        w_cntNext   = r_cnt;
        w_gntNext   = '0;
        w_ackNext   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_stateNext       = ST_GRANT;
                    w_winNext         = w_pick;
                    w_gntNext[w_pick] = 1'b1;
                end
            end
            ST_GRANT: begin
                // The pointer advances even when the winner withdrew, so it cannot starve others.
                w_ptrNext        = (r_win == PW'(N - 1)) ? '0 : r_win + PW'(1);
                w_ackNext[r_win] = i_req[r_win];
                if (w_j || w_k) begin
                    w_stateNext = ST_DWELL;
                    w_cntNext   = DW_W'(DWELL - 1);
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (r_cnt == '0) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_cntNext = r_cnt - DW_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_win   <= w_winNext;
            r_cnt   <= w_cntNext;
            r_gnt   <= w_gntNext;
            r_ack   <= w_ackNext;
        end
    end

    onoff_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .i_j   (w_j),
        .i_k   (w_k),
        .o_out (w_latch)
    );

    assign o_gnt       = r_gnt;
    assign o_ack       = r_ack;
    assign o_state_out = w_latch;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_onoff_resource_arbiter.sv
// Directed bench for onoff_resource_arbiter: a vector table for the basic
// grant/ack/dwell flow plus hand-written multi-cycle sequences.
module tb_onoff_resource_arbiter;

    localparam int N     = 4;
    localparam int DWELL = 8;

    typedef struct {
        logic [3:0] req;
        logic [3:0] want;
        logic [3:0] expGnt;
        logic [3:0] expAck;
        logic       expState;
        logic       expBusy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] wantOn = '0;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       stateOut;
    logic       busy;

    int nChecks = 0;
    int nFail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    onoff_resource_arbiter #(.N(N), .DWELL(DWELL)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_want_on   (wantOn),
        .o_gnt       (gnt),
        .o_ack       (ack),
        .o_state_out (stateOut),
        .o_busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eGnt, input logic [3:0] eAck,
                            input logic eState, input logic eBusy);
        checkOutput({tag, " gnt"}, gnt, eGnt);
        checkOutput({tag, " ack"}, ack, eAck);
        checkOutput({tag, " state"}, {3'b0, stateOut}, {3'b0, eState});
        checkOutput({tag, " busy"}, {3'b0, busy}, {3'b0, eBusy});
    endtask

    // Inputs change just after an edge; outputs are sampled 1 time unit after the next edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w);
        req    = r;
        wantOn = w;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checkAll(tag, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rrWant;
        logic       expLvl;

        // Reset, then req[2] turns the latch on and dwells for DWELL cycles.
        vecs.push_back('{4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1});
        vecs.push_back('{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1});
        for (int i = 0; i < 7; i++) vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0});
        // Already at the target level: ack without dwell.
        vecs.push_back('{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1});
        vecs.push_back('{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0});

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].want);
            checkAll($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expAck,
                     vecs[i].expState, vecs[i].expBusy);
        end

        // All four requesting with alternating targets: served 0,1,2,3,0, each with a dwell.
        doReset("rr reset");
        rrWant = 4'b0101;
        expLvl = 1'b0;
        for (int r = 0; r < 5; r++) begin
            int win;
            win = r % 4;
            applyStimulus(4'b1111, rrWant);
            checkAll($sformatf("rr%0d grant", r), 4'(1 << win), 4'b0000, expLvl, 1'b1);
            applyStimulus(4'b1111, rrWant);
            expLvl = rrWant[win];
            checkAll($sformatf("rr%0d ack", r), 4'b0000, 4'(1 << win), expLvl, 1'b1);
            for (int d = 0; d < DWELL; d++) begin
                applyStimulus(4'b1111, rrWant);
                checkAll($sformatf("rr%0d dwell%0d", r, d), 4'b0000, 4'b0000, expLvl, (d != DWELL - 1));
            end
        end

        // req[3] arrives while req[1] changes the level: it waits out the whole dwell.
        applyStimulus(4'b0010, 4'b0000);
        checkAll("hold gnt1", 4'b0010, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b1010, 4'b1000);
        checkAll("hold ack1", 4'b0000, 4'b0010, 1'b0, 1'b1);
        for (int d = 0; d < DWELL; d++) begin
            applyStimulus(4'b1000, 4'b1000);
            checkAll($sformatf("hold dwell%0d", d), 4'b0000, 4'b0000, 1'b0, (d != DWELL - 1));
        end
        applyStimulus(4'b1000, 4'b1000);
        checkAll("hold gnt3", 4'b1000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1000, 4'b1000);
        checkAll("hold ack3", 4'b0000, 4'b1000, 1'b1, 1'b1);
        for (int d = 0; d < DWELL; d++) begin
            applyStimulus(4'b0000, 4'b0000);
            checkAll($sformatf("hold3 dwell%0d", d), 4'b0000, 4'b0000, 1'b1, (d != DWELL - 1));
        end

        // req[1] withdrawn during GRANT: no ack, no change, pointer still moves to 2.
        applyStimulus(4'b0010, 4'b0000);
        checkAll("drop gnt", 4'b0010, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b0000, 4'b0000);
        checkAll("drop noack", 4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0110, 4'b0100);
        checkAll("drop ptr2", 4'b0100, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b0110, 4'b0100);
        checkAll("drop ack2", 4'b0000, 4'b0100, 1'b1, 1'b0);

        // Reset asserted in GRANT and in DWELL.
        applyStimulus(4'b0100, 4'b0000);
        checkAll("abort gnt", 4'b0100, 4'b0000, 1'b1, 1'b1);
        doReset("abort in grant");
        applyStimulus(4'b0000, 4'b0000);
        checkAll("abort noack", 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0101, 4'b0101);
        checkAll("abort first gnt", 4'b0001, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0101, 4'b0101);
        checkAll("abort first ack", 4'b0000, 4'b0001, 1'b1, 1'b1);
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkAll("abort in dwell", 4'b0000, 4'b0000, 1'b1, 1'b1);
        doReset("abort in dwell");
        applyStimulus(4'b1001, 4'b1001);
        checkAll("abort ptr0", 4'b0001, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1001, 4'b1001);
        checkAll("abort ptr0 ack", 4'b0000, 4'b0001, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
